// File: rtl/mercury_ddio_out_burst.sv
// mercury_ddio_out_burst
// DDR output channel. A WIDTH-bit bus of DDIO output cells sits behind a
// DEPTH-entry input FIFO. The output enable is framed with a preamble and a
// postamble of idle data around each burst.
// Ports:
//   clk, areset        single clock; asynchronous active-high reset
//   clkena             clock enable; when low, all state holds
//   in_valid/in_ready  core-side handshake; a word pair is accepted when both are high
//   datain_h/datain_l  word pair for the clk-high and clk-low halves
//   dout_h/dout_l/oe   registered data and output enable to the pad cell
//   padout             behavioural DDR pad value (clk ? dout_h : dout_l)
//   level              FIFO occupancy, 0..DEPTH
//   busy               sequencer is not idle
module mercury_ddio_out_burst #(
   parameter int unsigned WIDTH         = 8,
   parameter int unsigned DEPTH         = 4,
   parameter int unsigned OE_PREAMBLE   = 1,
   parameter int unsigned OE_POSTAMBLE  = 1,
   parameter int unsigned POWER_UP_HIGH = 0
) (
   input  logic                       clk,
   input  logic                       areset,
   input  logic                       clkena,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [WIDTH-1:0]           datain_h,
   input  logic [WIDTH-1:0]           datain_l,
   output logic [WIDTH-1:0]           dout_h,
   output logic [WIDTH-1:0]           dout_l,
   output logic                       oe,
   output logic [WIDTH-1:0]           padout,
   output logic [$clog2(DEPTH):0]     level,
   output logic                       busy
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned LW = AW + 1;
   localparam logic [WIDTH-1:0] IDLE_W = (POWER_UP_HIGH != 0) ? '1 : '0;
   localparam logic [3:0] PRE_LOAD  = 4'((OE_PREAMBLE  == 0) ? 0 : OE_PREAMBLE  - 1);
   localparam logic [3:0] POST_LOAD = 4'((OE_POSTAMBLE == 0) ? 0 : OE_POSTAMBLE - 1);

   typedef enum logic [1:0] {S_IDLE, S_PRE, S_BURST, S_POST} state_e;

   logic [2*WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]      wr_ptr_q, rd_ptr_q;
   logic [LW-1:0]      level_q;
   state_e             state_q;
   logic [3:0]         cnt_q;
   logic [WIDTH-1:0]   dout_h_q, dout_l_q;
   logic               oe_q;

   logic full_c, empty_c, push_c, pop_c;

   assign full_c   = (level_q == LW'(DEPTH));
   assign empty_c  = (level_q == '0);
   assign in_ready = clkena & ~full_c;
   assign push_c   = in_valid & in_ready;

   // A pop loads the head into the output registers. It happens on every
   // edge that enters or stays in BURST with data queued, so the first word
   // follows the preamble with no gap.
   always_comb begin
      pop_c = 1'b0;
      if (clkena && !empty_c) begin
         case (state_q)
            S_IDLE:  pop_c = (OE_PREAMBLE == 0);
            S_PRE:   pop_c = (cnt_q == 4'd0);
            default: pop_c = 1'b1;
         endcase
      end
   end

   // FIFO storage (no reset needed; validity is tracked by level_q)
   always_ff @(posedge clk) begin
      if (push_c) mem_q[wr_ptr_q] <= {datain_h, datain_l};
   end

   // FIFO pointers and occupancy; pointers wrap naturally since DEPTH is a power of 2
   always_ff @(posedge clk or posedge areset) begin
      if (areset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
      end else if (clkena) begin
         if (push_c) wr_ptr_q <= wr_ptr_q + AW'(1);
         if (pop_c)  rd_ptr_q <= rd_ptr_q + AW'(1);
         if (push_c && !pop_c)      level_q <= level_q + LW'(1);
         else if (!push_c && pop_c) level_q <= level_q - LW'(1);
      end
   end

   // Burst sequencer with registered oe and data
   always_ff @(posedge clk or posedge areset) begin
      if (areset) begin
         state_q  <= S_IDLE;
         cnt_q    <= 4'd0;
         oe_q     <= 1'b0;
         dout_h_q <= IDLE_W;
         dout_l_q <= IDLE_W;
      end else if (clkena) begin
         case (state_q)
            S_IDLE: begin
               if (!empty_c) begin
                  oe_q <= 1'b1;
                  if (OE_PREAMBLE == 0) begin
                     state_q <= S_BURST;
                  end else begin
                     state_q <= S_PRE;
                     cnt_q   <= PRE_LOAD;
                  end
               end
            end
            S_PRE: begin
               if (cnt_q == 4'd0) state_q <= S_BURST;
               else               cnt_q   <= cnt_q - 4'd1;
            end
            S_BURST: begin
               if (empty_c) begin
                  if (OE_POSTAMBLE == 0) begin
                     state_q <= S_IDLE;
                     oe_q    <= 1'b0;
                  end else begin
                     state_q <= S_POST;
                     cnt_q   <= POST_LOAD;
                  end
               end
            end
            default: begin
               // A word arriving during the postamble resumes the burst directly
               if (!empty_c) begin
                  state_q <= S_BURST;
               end else if (cnt_q == 4'd0) begin
                  state_q <= S_IDLE;
                  oe_q    <= 1'b0;
               end else begin
                  cnt_q <= cnt_q - 4'd1;
               end
            end
         endcase

         if (pop_c) begin
            {dout_h_q, dout_l_q} <= mem_q[rd_ptr_q];
         end else begin
            dout_h_q <= IDLE_W;
            dout_l_q <= IDLE_W;
         end
      end
   end

   assign dout_h = dout_h_q;
   assign dout_l = dout_l_q;
   assign oe     = oe_q;
   assign level  = level_q;
   assign busy   = (state_q != S_IDLE);
   assign padout = clk ? dout_h_q : dout_l_q;

endmodule

// File: tb/tb_mercury_ddio_out_burst.sv
// Directed bench for mercury_ddio_out_burst.
// A: defaults (PRE=1, POST=1, idle 00)
// B: POWER_UP_HIGH=1, PRE=0, POST=0
// C: PRE=4, POST=2 (deep preamble, used for the fill/freeze scenario)
module tb_mercury_ddio_out_burst;

   logic clk = 1'b0;
   logic areset, clkena;
   logic [7:0] din_h, din_l;

   logic a_valid, a_ready, a_oe, a_busy;
   logic [7:0] a_dh, a_dl, a_pad;
   logic [2:0] a_lvl;
   logic b_valid, b_ready, b_oe, b_busy;
   logic [7:0] b_dh, b_dl, b_pad;
   logic [2:0] b_lvl;
   logic c_valid, c_ready, c_oe, c_busy;
   logic [7:0] c_dh, c_dl, c_pad;
   logic [2:0] c_lvl;

   logic [7:0] wh [4];
   logic [7:0] wl [4];

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   mercury_ddio_out_burst #(.WIDTH(8), .DEPTH(4), .OE_PREAMBLE(1), .OE_POSTAMBLE(1),
                            .POWER_UP_HIGH(0)) u_a (
      .clk(clk), .areset(areset), .clkena(clkena), .in_valid(a_valid), .in_ready(a_ready),
      .datain_h(din_h), .datain_l(din_l), .dout_h(a_dh), .dout_l(a_dl), .oe(a_oe),
      .padout(a_pad), .level(a_lvl), .busy(a_busy));

   mercury_ddio_out_burst #(.WIDTH(8), .DEPTH(4), .OE_PREAMBLE(0), .OE_POSTAMBLE(0),
                            .POWER_UP_HIGH(1)) u_b (
      .clk(clk), .areset(areset), .clkena(clkena), .in_valid(b_valid), .in_ready(b_ready),
      .datain_h(din_h), .datain_l(din_l), .dout_h(b_dh), .dout_l(b_dl), .oe(b_oe),
      .padout(b_pad), .level(b_lvl), .busy(b_busy));

   mercury_ddio_out_burst #(.WIDTH(8), .DEPTH(4), .OE_PREAMBLE(4), .OE_POSTAMBLE(2),
                            .POWER_UP_HIGH(0)) u_c (
      .clk(clk), .areset(areset), .clkena(clkena), .in_valid(c_valid), .in_ready(c_ready),
      .datain_h(din_h), .datain_l(din_l), .dout_h(c_dh), .dout_l(c_dl), .oe(c_oe),
      .padout(c_pad), .level(c_lvl), .busy(c_busy));

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      areset = 1'b1; clkena = 1'b1;
      a_valid = 1'b0; b_valid = 1'b0; c_valid = 1'b0;
      din_h = 8'h00; din_l = 8'h00;
      tick; tick;
      checks++;
      if (a_oe !== 1'b0 || a_dh !== 8'h00 || a_dl !== 8'h00 || a_lvl !== 3'd0 || a_busy !== 1'b0) begin
         errors++;
         $display("FAIL reset_a: oe=%b dh=%h dl=%h lvl=%0d busy=%b, want 0 00 00 0 0", a_oe, a_dh, a_dl, a_lvl, a_busy);
      end
      checks++;
      if (b_oe !== 1'b0 || b_dh !== 8'hFF || b_dl !== 8'hFF || b_pad !== 8'hFF) begin
         errors++;
         $display("FAIL reset_b_idle_high: oe=%b dh=%h dl=%h pad=%h, want 0 FF FF FF", b_oe, b_dh, b_dl, b_pad);
      end
      areset = 1'b0;
      #1;
      checks++;
      if (a_ready !== 1'b1) begin
         errors++;
         $display("FAIL ready_after_reset: in_ready=%b, want 1", a_ready);
      end
      // clkena low: no handshake, no push
      clkena = 1'b0;
      #1;
      checks++;
      if (a_ready !== 1'b0) begin
         errors++;
         $display("FAIL ready_clkena_low: in_ready=%b, want 0", a_ready);
      end
      a_valid = 1'b1;
      tick;
      a_valid = 1'b0;
      checks++;
      if (a_lvl !== 3'd0 || a_busy !== 1'b0) begin
         errors++;
         $display("FAIL no_push_clkena_low: lvl=%0d busy=%b, want 0 0", a_lvl, a_busy);
      end
      clkena = 1'b1;
      tick;
   endtask

   task automatic test_single_word;
      din_h = 8'hA5; din_l = 8'h5A; a_valid = 1'b1;
      tick;                       // E0 push
      a_valid = 1'b0;
      checks++;
      if (a_lvl !== 3'd1 || a_oe !== 1'b0) begin
         errors++;
         $display("FAIL single_e0: lvl=%0d oe=%b, want 1 0", a_lvl, a_oe);
      end
      tick;                       // E1 preamble
      checks++;
      if (a_oe !== 1'b1 || a_dh !== 8'h00 || a_dl !== 8'h00 || a_busy !== 1'b1) begin
         errors++;
         $display("FAIL single_pre: oe=%b dh=%h dl=%h busy=%b, want 1 00 00 1", a_oe, a_dh, a_dl, a_busy);
      end
      tick;                       // E2 data
      checks++;
      if (a_oe !== 1'b1 || a_dh !== 8'hA5 || a_dl !== 8'h5A || a_lvl !== 3'd0 || a_pad !== 8'hA5) begin
         errors++;
         $display("FAIL single_data: oe=%b dh=%h dl=%h lvl=%0d pad=%h, want 1 A5 5A 0 A5", a_oe, a_dh, a_dl, a_lvl, a_pad);
      end
      @(negedge clk);
      #1;
      checks++;
      if (a_pad !== 8'h5A) begin
         errors++;
         $display("FAIL single_pad_low: pad=%h, want 5A", a_pad);
      end
      tick;                       // E3 postamble
      checks++;
      if (a_oe !== 1'b1 || a_dh !== 8'h00 || a_dl !== 8'h00 || a_busy !== 1'b1) begin
         errors++;
         $display("FAIL single_post: oe=%b dh=%h dl=%h busy=%b, want 1 00 00 1", a_oe, a_dh, a_dl, a_busy);
      end
      tick;                       // E4 idle
      checks++;
      if (a_oe !== 1'b0 || a_busy !== 1'b0 || a_dh !== 8'h00) begin
         errors++;
         $display("FAIL single_idle: oe=%b busy=%b dh=%h, want 0 0 00", a_oe, a_busy, a_dh);
      end
   endtask

   task automatic test_stream_a;
      logic [2:0] peak;
      peak = 3'd0;
      for (int k = 0; k < 8; k++) begin
         if (k < 4) begin
            din_h = wh[k]; din_l = wl[k]; a_valid = 1'b1;
            checks++;
            if (a_ready !== 1'b1) begin
               errors++;
               $display("FAIL stream_a_ready k=%0d: in_ready=%b, want 1", k, a_ready);
            end
         end else begin
            a_valid = 1'b0;
         end
         tick;
         if (a_lvl > peak) peak = a_lvl;
         if (k >= 2 && k <= 5) begin
            checks++;
            if (a_dh !== wh[k-2] || a_dl !== wl[k-2] || a_oe !== 1'b1) begin
               errors++;
               $display("FAIL stream_a_word k=%0d: dh=%h dl=%h oe=%b, want %h %h 1", k, a_dh, a_dl, a_oe, wh[k-2], wl[k-2]);
            end
         end
      end
      checks++;
      if (peak !== 3'd2 || a_oe !== 1'b0 || a_busy !== 1'b0) begin
         errors++;
         $display("FAIL stream_a_end: peak=%0d oe=%b busy=%b, want 2 0 0", peak, a_oe, a_busy);
      end
   endtask

   task automatic test_stream_b;
      logic [2:0] peak;
      peak = 3'd0;
      for (int k = 0; k < 6; k++) begin
         if (k < 4) begin
            din_h = wh[k]; din_l = wl[k]; b_valid = 1'b1;
            checks++;
            if (b_ready !== 1'b1) begin
               errors++;
               $display("FAIL stream_b_ready k=%0d: in_ready=%b, want 1", k, b_ready);
            end
         end else begin
            b_valid = 1'b0;
         end
         tick;
         if (b_lvl > peak) peak = b_lvl;
         if (k >= 1 && k <= 4) begin
            checks++;
            if (b_dh !== wh[k-1] || b_dl !== wl[k-1] || b_oe !== 1'b1) begin
               errors++;
               $display("FAIL stream_b_word k=%0d: dh=%h dl=%h oe=%b, want %h %h 1", k, b_dh, b_dl, b_oe, wh[k-1], wl[k-1]);
            end
         end
      end
      checks++;
      if (peak !== 3'd1 || b_oe !== 1'b0 || b_dh !== 8'hFF || b_dl !== 8'hFF) begin
         errors++;
         $display("FAIL stream_b_end: peak=%0d oe=%b dh=%h dl=%h, want 1 0 FF FF", peak, b_oe, b_dh, b_dl);
      end
   endtask

   task automatic test_power_up_high;
      din_h = 8'h3C; din_l = 8'hC3; b_valid = 1'b1;
      tick;                       // E0 push
      b_valid = 1'b0;
      checks++;
      if (b_oe !== 1'b0 || b_dh !== 8'hFF || b_lvl !== 3'd1) begin
         errors++;
         $display("FAIL puh_e0: oe=%b dh=%h lvl=%0d, want 0 FF 1", b_oe, b_dh, b_lvl);
      end
      tick;                       // E1 first word, no preamble
      checks++;
      if (b_oe !== 1'b1 || b_dh !== 8'h3C || b_dl !== 8'hC3 || b_busy !== 1'b1) begin
         errors++;
         $display("FAIL puh_e1: oe=%b dh=%h dl=%h busy=%b, want 1 3C C3 1", b_oe, b_dh, b_dl, b_busy);
      end
      tick;                       // E2 level==0, no postamble
      checks++;
      if (b_oe !== 1'b0 || b_dh !== 8'hFF || b_dl !== 8'hFF || b_busy !== 1'b0) begin
         errors++;
         $display("FAIL puh_e2: oe=%b dh=%h dl=%h busy=%b, want 0 FF FF 0", b_oe, b_dh, b_dl, b_busy);
      end
   endtask

   task automatic test_fill_freeze;
      for (int k = 0; k < 4; k++) begin
         din_h = wh[k]; din_l = wl[k]; c_valid = 1'b1;
         tick;                    // E0..E3 pushes, preamble counting
      end
      checks++;
      if (c_lvl !== 3'd4 || c_ready !== 1'b0 || c_oe !== 1'b1 || c_dh !== 8'h00) begin
         errors++;
         $display("FAIL fill_full: lvl=%0d ready=%b oe=%b dh=%h, want 4 0 1 00", c_lvl, c_ready, c_oe, c_dh);
      end
      clkena = 1'b0;
      for (int k = 0; k < 3; k++) begin
         tick;
         checks++;
         if (c_lvl !== 3'd4 || c_ready !== 1'b0 || c_oe !== 1'b1 || c_dh !== 8'h00 || c_busy !== 1'b1) begin
            errors++;
            $display("FAIL fill_frozen k=%0d: lvl=%0d ready=%b oe=%b dh=%h busy=%b, want 4 0 1 00 1", k, c_lvl, c_ready, c_oe, c_dh, c_busy);
         end
      end
      c_valid = 1'b0;
      clkena = 1'b1;
      tick;                       // E4 last preamble cycle
      checks++;
      if (c_oe !== 1'b1 || c_dh !== 8'h00 || c_lvl !== 3'd4) begin
         errors++;
         $display("FAIL fill_pre_tail: oe=%b dh=%h lvl=%0d, want 1 00 4", c_oe, c_dh, c_lvl);
      end
      for (int k = 0; k < 4; k++) begin
         tick;                    // E5..E8 words in order
         checks++;
         if (c_dh !== wh[k] || c_dl !== wl[k] || c_oe !== 1'b1) begin
            errors++;
            $display("FAIL fill_word k=%0d: dh=%h dl=%h oe=%b, want %h %h 1", k, c_dh, c_dl, c_oe, wh[k], wl[k]);
         end
      end
      tick; tick;                 // E9, E10 postamble (2 cycles)
      checks++;
      if (c_oe !== 1'b1 || c_dh !== 8'h00 || c_busy !== 1'b1 || c_lvl !== 3'd0) begin
         errors++;
         $display("FAIL fill_post: oe=%b dh=%h busy=%b lvl=%0d, want 1 00 1 0", c_oe, c_dh, c_busy, c_lvl);
      end
      tick;                       // E11 idle
      checks++;
      if (c_oe !== 1'b0 || c_busy !== 1'b0) begin
         errors++;
         $display("FAIL fill_idle: oe=%b busy=%b, want 0 0", c_oe, c_busy);
      end
   endtask

   task automatic test_post_resume;
      din_h = 8'hA1; din_l = 8'h1A; a_valid = 1'b1;
      tick;                       // E0
      a_valid = 1'b0;
      tick; tick;                 // E1 pre, E2 word
      checks++;
      if (a_dh !== 8'hA1 || a_oe !== 1'b1) begin
         errors++;
         $display("FAIL resume_first: dh=%h oe=%b, want A1 1", a_dh, a_oe);
      end
      din_h = 8'hB2; din_l = 8'h2B; a_valid = 1'b1;
      tick;                       // E3 enter POST, word pushed
      a_valid = 1'b0;
      checks++;
      if (a_oe !== 1'b1 || a_dh !== 8'h00 || a_lvl !== 3'd1 || a_busy !== 1'b1) begin
         errors++;
         $display("FAIL resume_post: oe=%b dh=%h lvl=%0d busy=%b, want 1 00 1 1", a_oe, a_dh, a_lvl, a_busy);
      end
      tick;                       // E4 back to BURST without preamble
      checks++;
      if (a_oe !== 1'b1 || a_dh !== 8'hB2 || a_dl !== 8'h2B || a_lvl !== 3'd0) begin
         errors++;
         $display("FAIL resume_word: oe=%b dh=%h dl=%h lvl=%0d, want 1 B2 2B 0", a_oe, a_dh, a_dl, a_lvl);
      end
      tick;                       // E5 postamble
      checks++;
      if (a_oe !== 1'b1 || a_dh !== 8'h00) begin
         errors++;
         $display("FAIL resume_post2: oe=%b dh=%h, want 1 00", a_oe, a_dh);
      end
      tick;                       // E6 idle
      checks++;
      if (a_oe !== 1'b0 || a_busy !== 1'b0) begin
         errors++;
         $display("FAIL resume_idle: oe=%b busy=%b, want 0 0", a_oe, a_busy);
      end
   endtask

   task automatic test_reset_mid_burst;
      for (int k = 0; k < 3; k++) begin
         din_h = wh[k]; din_l = wl[k]; a_valid = 1'b1;
         tick;
      end
      a_valid = 1'b0;
      checks++;
      if (a_dh !== wh[0] || a_lvl !== 3'd2 || a_oe !== 1'b1) begin
         errors++;
         $display("FAIL midrst_pre: dh=%h lvl=%0d oe=%b, want %h 2 1", a_dh, a_lvl, a_oe, wh[0]);
      end
      #2;
      areset = 1'b1;
      #1;
      checks++;
      if (a_oe !== 1'b0 || a_dh !== 8'h00 || a_dl !== 8'h00 || a_lvl !== 3'd0 || a_busy !== 1'b0) begin
         errors++;
         $display("FAIL midrst_async: oe=%b dh=%h dl=%h lvl=%0d busy=%b, want 0 00 00 0 0", a_oe, a_dh, a_dl, a_lvl, a_busy);
      end
      tick;
      areset = 1'b0;
      tick; tick;
      checks++;
      if (a_oe !== 1'b0 || a_dh !== 8'h00 || a_lvl !== 3'd0 || a_busy !== 1'b0) begin
         errors++;
         $display("FAIL midrst_dropped: oe=%b dh=%h lvl=%0d busy=%b, want 0 00 0 0", a_oe, a_dh, a_lvl, a_busy);
      end
   endtask

   initial begin
      wh[0] = 8'h11; wh[1] = 8'h22; wh[2] = 8'h33; wh[3] = 8'h44;
      wl[0] = 8'hE1; wl[1] = 8'hD2; wl[2] = 8'hC3; wl[3] = 8'hB4;
      test_reset;
      test_single_word;
      test_stream_a;
      test_stream_b;
      test_power_up_high;
      test_fill_freeze;
      test_post_resume;
      test_reset_mid_burst;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached, want completion");
      $fatal(1, "timeout");
   end

endmodule
